// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage.
// Decodes the MIPS opcode of each accepted instruction into extender control
// and a 32-bit operand, and buffers results in a 2-entry skid buffer so that
// in_ready comes straight from a flop. Supports a flush from the hazard unit.
module imm_gen_stage #(
    parameter int DEPTH = 2  // skid-buffer entries; only 2 is supported
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm32,
    output logic        out_ext_op,
    output logic [2:0]  out_kind,
    output logic        out_illegal
);

    // Extender kinds as seen on out_kind.
    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_SIGN   = 3'd1;
    localparam logic [2:0] KIND_ZERO   = 3'd2;
    localparam logic [2:0] KIND_UPPER  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JUMP   = 3'd5;

    // Occupancy states; the encoding equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [31:0] imm32;
        logic        ext_op;
        logic [2:0]  kind;
        logic        illegal;
    } entry_t;

    logic [1:0] r_state;
    logic       r_in_ready;
    entry_t     r_head;   // entry currently presented on out_*
    entry_t     r_tail;   // second entry, valid only in ST_TWO

    entry_t     w_dec;
    logic [5:0] w_op;
    logic [15:0] w_imm;
    logic       w_accept;
    logic       w_pop;
    logic [1:0] w_state_nxt;
    logic       w_load_head;
    logic       w_head_from_tail;
    logic       w_load_tail;

    assign w_op  = in_instr[31:26];
    assign w_imm = in_instr[15:0];

    // A flushed input is never accepted, even though the handshake completes.
    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_pop    = out_valid & out_ready;

    // Opcode decode and immediate formation for the incoming instruction.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        w_dec = '0;
        unique case (w_op)
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                w_dec.imm32  = {{16{w_imm[15]}}, w_imm};
                w_dec.ext_op = 1'b1;
                w_dec.kind   = KIND_SIGN;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_dec.imm32 = {16'b0, w_imm};
                w_dec.kind  = KIND_ZERO;
            end
            6'h0F: begin
                w_dec.imm32 = {w_imm, 16'b0};
                w_dec.kind  = KIND_UPPER;
            end
            6'h04, 6'h05: begin
                // Branch target wraps modulo 2^32 by virtue of the 32-bit add.
                w_dec.imm32  = in_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
                w_dec.ext_op = 1'b1;
                w_dec.kind   = KIND_BRANCH;
            end
            6'h02, 6'h03: begin
                w_dec.imm32 = {in_pc4[31:28], in_instr[25:0], 2'b00};
                w_dec.kind  = KIND_JUMP;
            end
            6'h00: begin
                w_dec.kind = KIND_NONE;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Occupancy transitions and which entry register gets loaded.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_head_from_tail = 1'b0;
        w_load_tail      = 1'b0;
        if (flush) begin
            // A same-cycle pop has already completed; everything else is dropped.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_head = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_head = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_load_tail = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_head_from_tail = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State, registered in_ready and entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the two entry registers are reset too (they are tiny), so
            // out_* is never X after reset even though it is don't-care when
            // out_valid is low.
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt < 2'(DEPTH));
            if (w_load_head) begin
                r_head <= w_dec;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_dec;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_imm32   = r_head.imm32;
    assign out_ext_op  = r_head.ext_op;
    assign out_kind    = r_head.kind;
    assign out_illegal = r_head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: a queue-based reference model checked
// every cycle, plus directed vectors with hand-computed expected outputs.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm32;
    logic        out_ext_op;
    logic [2:0]  out_kind;
    logic        out_illegal;

    int n_vec  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    typedef struct {
        logic [31:0] imm;
        logic        ext;
        logic [2:0]  kind;
        logic        ill;
    } res_t;

    res_t q[$];

    imm_gen_stage #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc4     (in_pc4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm32  (out_imm32),
        .out_ext_op (out_ext_op),
        .out_kind   (out_kind),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic res_t model_decode(input logic [31:0] ins, input logic [31:0] pc4);
        res_t r;
        int   op;
        int   imm_s;
        op    = int'(ins >> 26);
        imm_s = int'($signed(ins[15:0]));
        r.imm = 0; r.ext = 0; r.kind = 0; r.ill = 0;
        if (op == 8 || op == 9 || op == 10 || op == 11 || op == 35 || op == 43) begin
            r.imm = 32'(imm_s); r.ext = 1; r.kind = 1;
        end else if (op == 12 || op == 13 || op == 14) begin
            r.imm = ins & 32'h0000FFFF; r.kind = 2;
        end else if (op == 15) begin
            r.imm = ins << 16; r.kind = 3;
        end else if (op == 4 || op == 5) begin
            r.imm = pc4 + 32'(imm_s * 4); r.ext = 1; r.kind = 4;
        end else if (op == 2 || op == 3) begin
            r.imm = (pc4 & 32'hF0000000) | ((ins & 32'h03FFFFFF) * 4); r.kind = 5;
        end else if (op != 0) begin
            r.ill = 1;
        end
        return r;
    endfunction

    // Reference model: FIFO of results, capacity 2.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            automatic bit pop = (q.size() > 0) && out_ready;
            automatic bit acc = in_valid && (q.size() < 2) && !flush;
            if (pop) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(model_decode(in_instr, in_pc4));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("mdl_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                check("mdl_imm32", out_imm32, q[0].imm);
                check("mdl_ext_op", 32'(out_ext_op), 32'(q[0].ext));
                check("mdl_kind", 32'(out_kind), 32'(q[0].kind));
                check("mdl_illegal", 32'(out_illegal), 32'(q[0].ill));
            end
        end
    end

    // Drive one cycle of inputs (called at a negedge), return at next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rst);
        in_valid  = v;
        in_instr  = ins;
        in_pc4    = pc;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] imm,
                              input logic ext, input logic [2:0] kind, input logic ill);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_imm"}, out_imm32, imm);
        check({name, "_ext"}, 32'(out_ext_op), 32'(ext));
        check({name, "_kind"}, 32'(out_kind), 32'(kind));
        check({name, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic expect_reset_vals(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        check({name, "_imm"}, out_imm32, 32'd0);
        check({name, "_ext"}, 32'(out_ext_op), 32'd0);
        check({name, "_kind"}, 32'(out_kind), 32'd0);
        check({name, "_ill"}, 32'(out_illegal), 32'd0);
    endtask

    localparam logic [31:0] I_ADDIU = 32'h2408FFFF;
    localparam logic [31:0] I_ORI   = 32'h3408FFFF;
    localparam logic [31:0] I_LUI   = 32'h3C081234;
    localparam logic [31:0] I_BEQ   = 32'h1000FFFF;
    localparam logic [31:0] I_BEQ2  = 32'h10000010;
    localparam logic [31:0] I_J     = 32'h08100004;
    localparam logic [31:0] I_ADDI  = 32'h21088000;
    localparam logic [31:0] I_ANDI  = 32'h310800FF;
    localparam logic [31:0] I_SLTI  = 32'h29087FFF;
    localparam logic [31:0] I_BAD   = 32'hFC000000;
    localparam logic [31:0] I_RTYPE = 32'h012A4020;

    initial begin
        // Reset
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        reset  = 1'b0;
        chk_en = 1'b1;
        expect_reset_vals("rst");

        // First instruction, latency one cycle
        step(1, I_ADDIU, 32'h0, 1, 0, 0);
        expect_out("addiu", 32'hFFFFFFFF, 1, 3'd1, 0);

        // Back-to-back stream, in_ready held high
        check("stream_rdy0", 32'(in_ready), 32'd1);
        step(1, I_ORI, 32'h0, 1, 0, 0);
        expect_out("ori", 32'h0000FFFF, 0, 3'd2, 0);
        check("stream_rdy1", 32'(in_ready), 32'd1);
        step(1, I_LUI, 32'h0, 1, 0, 0);
        expect_out("lui", 32'h12340000, 0, 3'd3, 0);
        check("stream_rdy2", 32'(in_ready), 32'd1);
        step(1, I_BEQ, 32'h00400010, 1, 0, 0);
        expect_out("beq", 32'h0040000C, 1, 3'd4, 0);
        check("stream_rdy3", 32'(in_ready), 32'd1);
        step(1, I_J, 32'h90000000, 1, 0, 0);
        expect_out("j", 32'h90400010, 0, 3'd5, 0);
        step(1, I_BEQ2, 32'hFFFFFFF0, 1, 0, 0);
        expect_out("beq_wrap", 32'h00000030, 1, 3'd4, 0);
        step(0, 0, 0, 1, 0, 0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Stall: three offered, two accepted, third held
        step(1, I_ADDI, 32'h0, 0, 0, 0);
        expect_out("stall_a", 32'hFFFF8000, 1, 3'd1, 0);
        check("stall_rdy_one", 32'(in_ready), 32'd1);
        step(1, I_ANDI, 32'h0, 0, 0, 0);
        check("stall_rdy_full", 32'(in_ready), 32'd0);
        expect_out("stall_hold1", 32'hFFFF8000, 1, 3'd1, 0);
        step(1, I_SLTI, 32'h0, 0, 0, 0);
        check("stall_rdy_full2", 32'(in_ready), 32'd0);
        expect_out("stall_hold2", 32'hFFFF8000, 1, 3'd1, 0);
        step(1, I_SLTI, 32'h0, 1, 0, 0);
        expect_out("stall_b", 32'h000000FF, 0, 3'd2, 0);
        step(1, I_SLTI, 32'h0, 1, 0, 0);
        expect_out("stall_c", 32'h00007FFF, 1, 3'd1, 0);
        step(0, 0, 0, 1, 0, 0);
        check("stall_drain", 32'(out_valid), 32'd0);

        // Illegal opcode and R-type
        step(1, I_BAD, 32'h0, 1, 0, 0);
        expect_out("illegal", 32'h0, 0, 3'd0, 1);
        step(1, I_RTYPE, 32'h0, 1, 0, 0);
        expect_out("rtype", 32'h0, 0, 3'd0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Flush with two entries buffered and a same-cycle input
        step(1, I_LUI, 32'h0, 0, 0, 0);
        step(1, I_ORI, 32'h0, 0, 0, 0);
        check("fl_full", 32'(in_ready), 32'd0);
        step(1, I_J, 32'h90000000, 0, 1, 0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        check("fl_after_valid", 32'(out_valid), 32'd0);
        // Flush from one entry while an input is accepted
        step(1, I_LUI, 32'h0, 0, 0, 0);
        step(1, I_ADDIU, 32'h0, 1, 1, 0);
        check("fl1_valid", 32'(out_valid), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        check("fl1_after_valid", 32'(out_valid), 32'd0);
        step(1, I_ANDI, 32'h0, 1, 0, 0);
        expect_out("post_flush", 32'h000000FF, 0, 3'd2, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset while full and stalled
        step(1, I_LUI, 32'h0, 0, 0, 0);
        step(1, I_ADDI, 32'h0, 0, 0, 0);
        step(1, I_J, 32'h90000000, 0, 0, 1);
        expect_reset_vals("midrst");
        step(1, I_ORI, 32'h0, 1, 0, 0);
        expect_out("post_rst", 32'h0000FFFF, 0, 3'd2, 0);
        step(0, 0, 0, 1, 0, 0);
        check("post_rst_drain", 32'(out_valid), 32'd0);
        step(0, 0, 0, 1, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined immediate-generation stage between instruction fetch/decode and execute.
- Decodes the opcode of each accepted instruction into the extender control (sign/zero/upper/branch/jump) and forms the 32-bit operand.
- Uses a 2-entry skid buffer with valid/ready handshakes on both sides, so that in_ready is a registered signal.
- Also supports a flush from the hazard/branch unit.

Parameters:
- DEPTH, 2, number of skid-buffer entries; fixed at 2, and no other value is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discards all buffered entries and any same-cycle input
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage can accept; a registered output
- in_instr  input  32  MIPS instruction word
- in_pc4  input  32  PC+4 of in_instr
- out_valid  output  1  out_* fields are valid
- out_ready  input  1  downstream accepts
- out_imm32  output  32  generated immediate
- out_ext_op  output  1  1 = sign-extend was applied
- out_kind  output  3  0 NONE, 1 SIGN, 2 ZERO, 3 UPPER, 4 BRANCH, 5 JUMP
- out_illegal  output  1  opcode not recognised

Behaviour:
- Reset: out_valid=0, in_ready=1, out_imm32=0, out_ext_op=0, out_kind=0, out_illegal=0, occupancy=0.
- Handshake rules:
  - Input transfer occurs when in_valid&in_ready at a rising edge.
  - Output transfer occurs when out_valid&out_ready at a rising edge.
  - out_* must hold stable while out_valid=1 and out_ready=0.
- Decode, with op=in_instr[31:26] and imm=in_instr[15:0], performed at input acceptance:
  - 0x08, 0x09, 0x0A, 0x0B, 0x23, 0x2B -> SIGN: {{16{imm[15]}},imm}, ext_op=1.
  - 0x0C, 0x0D, 0x0E -> ZERO: {16'b0,imm}, ext_op=0.
  - 0x0F -> UPPER: {imm,16'b0}, ext_op=0.
  - 0x04, 0x05 -> BRANCH: in_pc4 + ({{14{imm[15]}},imm,2'b00}), wrapping mod 2^32, ext_op=1.
  - 0x02, 0x03 -> JUMP: {in_pc4[31:28],in_instr[25:0],2'b00}, ext_op=0.
  - 0x00 -> NONE, imm32=0, ext_op=0.
  - Any other opcode -> NONE, imm32=0, illegal=1.
- Result entry is {imm32, ext_op, kind, illegal}.
- State machine on occupancy:
  - EMPTY:
    - accept -> ONE; the entry appears on out_* next cycle. Latency is 1 cycle, with no same-cycle bypass.
  - ONE:
    - accept & !pop -> TWO.
    - pop & !accept -> EMPTY.
    - accept & pop -> ONE; out_* takes the new entry.
  - TWO:
    - in_ready=0. pop -> ONE; the second entry moves to the output.
    - Accept is impossible in this state.
- in_ready is registered and equals 1 iff next occupancy < 2.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- Flush:
  - Next occupancy becomes 0, out_valid=0 next cycle, and in_ready=1 next cycle.
  - An input handshaking in the same cycle as flush is discarded.
  - A pop in the same cycle as flush counts as completed; the downstream saw it.
- Reset overrides flush and all handshakes. Reset mid-operation drops all entries.
- out_* data when out_valid=0 is don't-care for checking but must not be X after reset; the implementation holds the last value.

Test Plan:
- Reset, then send 0x2408FFFF (addiu, imm 0xFFFF) with out_ready=1 -> one cycle later out_valid=1, imm32=0xFFFFFFFF, ext_op=1, kind=1.
- Stream in back-to-back order:
  - 0x3408FFFF (ori) -> 0x0000FFFF, kind 2.
  - 0x3C081234 (lui) -> 0x12340000, kind 3.
  - 0x1000FFFF (beq) with pc4=0x00400010 -> 0x0040000C, kind 4.
  - 0x08100004 (j) with pc4=0x90000000 -> 0x90400010, kind 5.
  - All arrive in order, with one result per cycle and in_ready held at 1.
- Hold out_ready=0 and offer 3 instructions -> first two accepted, in_ready=0 in the following cycle, third held. Raise out_ready -> all three emerge in order with no loss. Out_* stays stable during the stall.
- Send opcode 0x3F -> out_illegal=1, imm32=0, kind=0. Send an R-type 0x012A4020 -> kind=0, illegal=0.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1, and neither the buffered entries nor the flushed input ever appear.
- Assert reset while TWO is full and out_ready=0 -> next cycle all outputs are at their reset values. The first post-reset instruction is the first one output.
